// File: rtl/aprx_fp_expand.sv
// aprx_fp_expand: unpacks 2x binary16alt or 4x binary8 lanes into binary32, one lane per beat
`timescale 1ns/1ps
module aprx_fp_expand #(
   parameter bit FTZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [1:0]  out_lane,
   output logic        out_last
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] word_q, word_d;
   logic        mode_q, mode_d;
   logic [15:0] h;
   logic [7:0]  b, e8;
   logic [22:0] m23;
   logic        nan16, sub, inf, zero, acc, xfer;

   // convert the lane currently selected by the lane counter
   always_comb begin
      h        = word_q[16*lane_q[0] +: 16];
      b        = word_q[8*lane_q +: 8];
      nan16    = &h[14:7] & |h[6:0];
      sub      = ~|b[6:2];
      inf      = &b[6:2];
      zero     = sub & (FTZ | ~|b[1:0]);
      e8       = zero ? 8'd0 : inf ? 8'hFF : sub ? (b[1] ? 8'd112 : 8'd111) : {3'b0, b[6:2]} + 8'd112;
      m23      = zero ? 23'd0 : inf ? {|b[1:0], b[0], 21'b0} : sub ? {b[1] & b[0], 22'b0} : {b[1:0], 21'b0};
      out_data = mode_q ? {b[7], e8, m23} : {h[15:7], h[6] | nan16, h[5:0], 16'b0};
      out_lane = lane_q;
      out_last = mode_q ? &lane_q : lane_q[0];
   end

   // handshakes and next-state: a last-lane transfer can accept a new word in the same cycle
   always_comb begin
      out_valid = state_q == EMIT;
      in_ready  = ~rst & (state_q == IDLE | (out_valid & out_ready & out_last));
      acc       = in_valid & in_ready;
      xfer      = out_valid & out_ready;
      state_d   = state_q;
      lane_d    = lane_q;
      word_d    = word_q;
      mode_d    = mode_q;
      if (acc) begin
         state_d = EMIT;
         lane_d  = 2'd0;
         word_d  = in_data;
         mode_d  = in_mode;
      end else if (xfer & out_last) begin
         state_d = IDLE;
         lane_d  = 2'd0;
      end else if (xfer) begin
         lane_d  = lane_q + 2'd1;
      end
   end

   // state, lane counter and captured word; reset drops any word in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lane_q  <= 2'd0;
         word_q  <= 32'd0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         mode_q  <= mode_d;
      end
   end
endmodule

// File: tb/tb_aprx_fp_expand.sv
// tb_aprx_fp_expand: random and directed checks of both FTZ variants against a lane-queue model
`timescale 1ns/1ps
module tb_aprx_fp_expand;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
   logic [31:0] out_data0, out_data1;
   logic [1:0]  out_lane0, out_lane1;
   int          n_chk = 0, n_fail = 0;
   bit          rand_ready = 1'b0, hold_ready = 1'b1;
   typedef struct {logic [31:0] d0; logic [31:0] d1; logic [1:0] lane; logic last;} beat_t;
   beat_t       q[$];
   logic [31:0] seen0[$], seen1[$];

   always #5 clk = ~clk;

   aprx_fp_expand #(.FTZ(1'b0)) dut0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_lane(out_lane0), .out_last(out_last0));
   aprx_fp_expand #(.FTZ(1'b1)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_lane(out_lane1), .out_last(out_last1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] conv8(input logic [7:0] b, input bit ftz);
      int e = int'(b[6:2]);
      int m = int'(b[1:0]);
      int p;
      logic [31:0] s = {b[7], 31'b0};
      if (e == 31) return s | 32'h7F80_0000 | (m != 0 ? ((32'(m) << 21) | 32'h0040_0000) : 32'd0);
      if (e == 0 && (m == 0 || ftz)) return s;
      if (e == 0) begin
         p = m >> 1;
         return s | (32'(111 + p) << 23) | (32'(m - (1 << p)) << (23 - p));
      end
      return s | (32'(e + 112) << 23) | (32'(m) << 21);
   endfunction

   function automatic logic [31:0] conv16(input logic [15:0] h);
      logic [31:0] r = {h, 16'b0};
      if (h[14:7] == 8'hFF && h[6:0] != 7'd0) r[22] = 1'b1;
      return r;
   endfunction

   task automatic push_word(input logic [31:0] d, input logic m);
      beat_t t;
      int n = m ? 4 : 2;
      for (int k = 0; k < n; k++) begin
         t.d0   = m ? conv8(d[8*k +: 8], 1'b0) : conv16(d[16*k +: 16]);
         t.d1   = m ? conv8(d[8*k +: 8], 1'b1) : conv16(d[16*k +: 16]);
         t.lane = 2'(k);
         t.last = k == n - 1;
         q.push_back(t);
      end
   endtask

   always @(negedge clk) begin
      bit ev, eir;
      if (rst) begin
         chk("reset_out", {out_valid0, out_valid1, in_ready0, in_ready1, out_last0, out_last1,
                           out_lane0, out_lane1, out_data0 | out_data1}, 64'd0);
         q.delete();
      end else begin
         ev  = q.size() != 0;
         eir = ev ? (out_ready && q[0].last) : 1'b1;
         chk("out_valid", {out_valid0, out_valid1}, {ev, ev});
         chk("in_ready", {in_ready0, in_ready1}, {eir, eir});
         if (ev) begin
            chk("data_ftz0", out_data0, q[0].d0);
            chk("data_ftz1", out_data1, q[0].d1);
            chk("lane_last", {out_lane0, out_lane1, out_last0, out_last1},
                {q[0].lane, q[0].lane, q[0].last, q[0].last});
            if (out_ready) begin
               seen0.push_back(out_data0);
               seen1.push_back(out_data1);
               void'(q.pop_front());
            end
         end
         if (in_valid && eir) push_word(in_data, in_mode);
      end
   end

   initial forever begin
      @(posedge clk);
      #2 out_ready = rand_ready ? ($urandom_range(3) != 0) : hold_ready;
   end

   task automatic send(input logic [31:0] d, input logic m);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready0;
         @(posedge clk);
         #2;
      end
      chk("accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = !out_valid0 && q.size() == 0;
      end
      @(posedge clk);
      #2;
      chk("idle", 64'(ok), 64'd1);
   endtask

   task automatic clear_seen();
      seen0.delete();
      seen1.delete();
   endtask

   initial begin
      bit ok;
      logic [31:0] d;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #2;
      clear_seen();
      send(32'h41A4_4221, 1'b0);
      in_valid = 1'b0;
      wait_idle();
      chk("b16_count", 64'(seen0.size()), 64'd2);
      chk("b16_lane0", seen0[0], 32'h4221_0000);
      chk("b16_lane1", seen0[1], 32'h41A4_0000);
      clear_seen();
      send(32'h807C_3C41, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      chk("b8_count", 64'(seen1.size()), 64'd4);
      chk("b8_lane0", seen1[0], 32'h4020_0000);
      chk("b8_lane1", seen1[1], 32'h3F80_0000);
      chk("b8_lane2", seen1[2], 32'h7F80_0000);
      chk("b8_lane3", seen1[3], 32'h8000_0000);
      clear_seen();
      send(32'h0000_037D, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      chk("sub_nan", seen0[0], 32'h7FE0_0000);
      chk("sub_ftz0", seen0[1], 32'h3840_0000);
      chk("sub_ftz1", seen1[1], 32'h0000_0000);
      chk("sub_zero", {seen0[2], seen0[3]}, 64'd0);
      @(negedge clk);
      hold_ready = 1'b0;
      @(posedge clk);
      #2;
      clear_seen();
      send(32'hFF80_7F81, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      hold_ready = 1'b1;
      @(negedge clk);
      hold_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_lane", {out_valid0, out_lane0}, {1'b1, 2'd1});
         chk("stall_in_ready", 64'(in_ready0), 64'd0);
      end
      hold_ready = 1'b1;
      wait_idle();
      chk("quiet_nan", seen0[0], 32'h7FC1_0000);
      chk("neg_inf", seen0[1], 32'hFF80_0000);
      clear_seen();
      send(32'h1234_5678, 1'b0);
      send(32'h9ABC_DEF0, 1'b1);
      send(32'h0F0F_F0F0, 1'b0);
      send(32'h8384_7C7D, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      chk("b2b_count", 64'(seen0.size()), 64'd12);
      send(32'h807C_3C41, 1'b1);
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid0 && out_lane0 == 2'd2;
      end
      chk("reach_lane2", 64'(ok), 64'd1);
      #1 rst = 1'b1;
      #1 chk("rst_async", {out_valid0, in_ready0, out_last0, out_lane0, out_data0}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #2;
      clear_seen();
      send(32'h1122_3344, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      chk("post_rst_count", 64'(seen0.size()), 64'd4);
      chk("post_rst_lane0", seen0[0], 32'h4080_0000);
      @(negedge clk);
      rand_ready = 1'b1;
      @(posedge clk);
      #2;
      for (int w = 0; w < 300; w++) begin
         d = $urandom;
         case ($urandom_range(3))
            0: d = d & 32'h8383_8383;
            1: d = d | 32'h7C7C_7C7C;
            default: ;
         endcase
         send(d, 1'($urandom_range(1)));
         if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2;
         end
      end
      in_valid = 1'b0;
      wait_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/aprx_fp_expand.md
APRX_FP_EXPAND -- requirements
Module: aprx_fp_expand

Interface
REQ-001 SHALL have parameter FTZ, default 1: 1 flushes binary8 subnormals to signed zero, 0 normalizes them.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a packed input word is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the packed word this cycle.
REQ-006 SHALL have port in_data, input, 32 bits: packed word, either 2x binary16alt (1/8/7) or 4x binary8 (1/5/2).
REQ-007 SHALL have port in_mode, input, 1 bit: 0 = binary16alt lanes, 1 = binary8 lanes; sampled only at acceptance.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a converted binary32 value.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer takes out_data this cycle.
REQ-010 SHALL have port out_data, output, 32 bits: binary32 result for the current lane.
REQ-011 SHALL have port out_lane, output, 2 bits: index of the current lane.
REQ-012 SHALL have port out_last, output, 1 bit: the current lane is the final lane of the word.

Function
REQ-013 SHALL implement FSM states IDLE and EMIT, plus a 2-bit lane counter and registered copies of the word and the mode.
REQ-014 SHALL use these handshakes: input accepted when in_valid & in_ready; output transferred when out_valid & out_ready.
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==EMIT & out_ready & out_last), and hold it at 0 while rst is high.
REQ-016 SHALL, on acceptance, latch in_data and in_mode, set lane=0 and enter EMIT; out_valid rises the next cycle (latency 1).
REQ-017 SHALL, in EMIT, keep out_valid=1; out_data, out_lane and out_last SHALL stay stable while out_ready=0.
REQ-018 SHALL, on a transfer of a non-last lane, increment lane by 1.
REQ-019 SHALL, on a transfer of the last lane with a simultaneous acceptance, stay in EMIT at lane 0 of the new word, with no bubble.
REQ-020 SHALL, on a transfer of the last lane without acceptance, return to IDLE and set out_valid=0.
REQ-021 SHALL use lane order LSB first: lane k = word[16k+15:16k] in mode 0 (last lane 1), and word[8k+7:8k] in mode 1 (last lane 3).
REQ-022 SHALL register outputs; out_data, out_lane and out_last SHALL all be derived from the registered word and the lane counter.
REQ-023 SHALL convert binary16alt as {s, e[7:0], m[6:0], 16'b0}, so zero, inf and subnormals pass through bit-exact.
REQ-024 SHALL convert a binary16alt NaN (e=255, m!=0) with bit 22 forced to 1 (quieted).
REQ-025 SHALL convert binary8 normals (1<=e<=30) as exp32 = e+112 and mant32 = {m[1:0], 21'b0}.
REQ-026 SHALL convert binary8 e=31 to exp32 = 255, with m=0 giving inf and m!=0 giving {m, 21'b0} with bit 22 set.
REQ-027 SHALL convert binary8 e=0, m=0 to signed zero.
REQ-028 SHALL, for binary8 e=0, m!=0, produce signed zero when FTZ=1.
REQ-029 SHALL, for binary8 e=0, m!=0 with FTZ=0, map m=1 to exp 111 / mant 0, m=2 to exp 112 / mant 0, and m=3 to exp 112 / mant 0x400000.
REQ-030 SHALL always preserve the sign bit.

Reset
REQ-031 SHALL, while rst is high, force state=IDLE, lane=0, out_valid=0, out_data=0, out_lane=0, out_last=0 and in_ready=0, regardless of clk.
REQ-032 SHALL, on reset mid-word, discard the remaining lanes; after release no stale lane is emitted, and in_ready=1 from the first cycle after release.

Verification
REQ-033 SHALL pass: mode 0, in_data=0x41A44221, out_ready=1 -> 0x42210000 (lane 0), then 0x41A40000 (lane 1, out_last=1), then IDLE.
REQ-034 SHALL pass: mode 1, in_data=0x807C3C41 -> 0x40200000, 0x3F800000, 0x7F800000, 0x80000000 in order, with out_last only on lane 3.
REQ-035 SHALL pass: mode 1, in_data=0x0000037D, FTZ=0 -> 0x7FE00000, 0x38400000, 0x00000000, 0x00000000; with FTZ=1 lane 1 = 0x00000000.
REQ-036 SHALL pass: out_ready held 0 for 3 cycles at lane 1 -> out_data stable and in_ready=0 throughout; resumes correctly.
REQ-037 SHALL pass: back-to-back words with in_valid held high -> in_ready=1 on each last-lane transfer, continuous out_valid, no lost or duplicated lane.
REQ-038 SHALL pass: rst pulsed during lane 2 of a mode-1 word -> outputs zero immediately; after release the next word emits lane 0 first.
